shift_serializer: RTL and testbench

//  Parallel-to-serial transmitter for the I2C peripheral's SDA-out path. Accepts a WIDTH-bit

---
 rtl/shift_serializer_pkg.sv | 26 ++
 rtl/shift_serializer.sv | 161 ++++++++++++++++
 tb/tb_shift_serializer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/shift_serializer_pkg.sv
// ---------------------------------------------------------------------------
// shift_serializer_pkg
//   Shared definitions for the I2C SDA-out serializer and the protocol FSM
//   that drives it.
//   - ser_state_e   : serializer state encoding
//   - LINE_RELEASED : level placed on the SDA driver input when the line is
//                     let go (open-drain: 1 = released, pulled up externally)
//   - ser_count_w() : bit-count width needed for a given word width
// ---------------------------------------------------------------------------
package shift_serializer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_SHIFT    = 2'd1,
    ST_ACK_REL  = 2'd2,
    ST_ACK_WAIT = 2'd3
  } ser_state_e;

  localparam logic LINE_RELEASED = 1'b1;

  // The count must be able to represent WIDTH itself.
  function automatic int ser_count_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/shift_serializer.sv
// ---------------------------------------------------------------------------
// shift_serializer
//   Parallel-to-serial transmitter for the I2C SDA-out path. A WIDTH-bit word
//   is accepted over valid/ready, then one bit is driven per shift_en strobe
//   (MSB- or LSB-first). With ACK_SLOT set, the line is released on one more
//   shift_en and the receiver's ACK/NACK is captured on the next sample_en.
//
// Parameters
//   WIDTH      word width, 2..32
//   MSB_FIRST  1: in_data[WIDTH-1] first, 0: in_data[0] first
//   ACK_SLOT   1: append release + ACK sample phase
//
// Ports
//   clk, reset      clock, synchronous active-high reset
//   in_data/valid   word to send, captured when in_valid & in_ready
//   in_ready        high only in IDLE
//   shift_en        SCL-low strobe: drive the next bit / release for ACK
//   sample_en       SCL-high strobe: used only to sample the ACK bit
//   ack_in          SDA as seen on the bus (0 = ACK)
//   abort           drop the transfer immediately, no done pulse
//   out             serial data to the SDA driver (1 = released)
//   busy            high in any state but IDLE
//   done            one-cycle completion pulse
//   nack            ack_in captured in the last completed ACK slot
// ---------------------------------------------------------------------------
module shift_serializer
  import shift_serializer_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit ACK_SLOT  = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             shift_en,
  input  logic             sample_en,
  input  logic             ack_in,
  input  logic             abort,
  output logic             out,
  output logic             busy,
  output logic             done,
  output logic             nack
);

  localparam int              CW       = ser_count_w(WIDTH);
  localparam logic [CW-1:0]   LAST_IDX = CW'(WIDTH - 1);

  ser_state_e       state_reg, state_next;
  logic [WIDTH-1:0] shreg_reg, shreg_next;
  logic [CW-1:0]    count_reg, count_next;
  logic             out_reg,   out_next;
  logic             done_reg,  done_next;
  logic             nack_reg,  nack_next;

  // Bit presented to the line on the next shift_en, and the register after
  // that bit has been consumed.
  logic             tx_bit;
  logic [WIDTH-1:0] shreg_shifted;

  assign tx_bit        = MSB_FIRST ? shreg_reg[WIDTH-1] : shreg_reg[0];
  assign shreg_shifted = MSB_FIRST ? {shreg_reg[WIDTH-2:0], 1'b0}
                                   : {1'b0, shreg_reg[WIDTH-1:1]};

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      shreg_reg <= '0;
      count_reg <= '0;
      out_reg   <= LINE_RELEASED;
      done_reg  <= 1'b0;
      nack_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shreg_reg <= shreg_next;
      count_reg <= count_next;
      out_reg   <= out_next;
      done_reg  <= done_next;
      nack_reg  <= nack_next;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state / datapath
  // -------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    shreg_next = shreg_reg;
    count_next = count_reg;
    out_next   = out_reg;
    done_next  = 1'b0;
    nack_next  = nack_reg;

    if (abort) begin
      // Abort wins over every strobe; nack keeps the last completed result.
      state_next = ST_IDLE;
      count_next = '0;
      out_next   = LINE_RELEASED;
    end else begin
      unique case (state_reg)
        ST_IDLE: begin
          // The line is left as-is on load; the first bit only appears on
          // the first shift_en after the accept.
          if (in_valid) begin
            shreg_next = in_data;
            count_next = '0;
            state_next = ST_SHIFT;
          end
        end

        ST_SHIFT: begin
          if (shift_en) begin
            out_next   = tx_bit;
            shreg_next = shreg_shifted;
            count_next = count_reg + 1'b1;
            if (count_reg == LAST_IDX) begin
              if (ACK_SLOT) begin
                state_next = ST_ACK_REL;
              end else begin
                done_next  = 1'b1;
                state_next = ST_IDLE;
              end
            end
          end
        end

        ST_ACK_REL: begin
          // Let go of SDA so the receiver can drive the ACK bit.
          if (shift_en) begin
            out_next   = LINE_RELEASED;
            state_next = ST_ACK_WAIT;
          end
        end

        ST_ACK_WAIT: begin
          if (sample_en) begin
            nack_next  = ack_in;
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end
        end

        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign in_ready = (state_reg == ST_IDLE);
  assign busy     = (state_reg != ST_IDLE);
  assign out      = out_reg;
  assign done     = done_reg;
  assign nack     = nack_reg;

endmodule

// File: tb/tb_shift_serializer.sv
// ---------------------------------------------------------------------------
// tb_shift_serializer
//   Three serializer instances with different parameter sets are exercised
//   through one transfer task. The expected bit stream is derived directly
//   from the word: bit i of the stream is word[W-1-i] (MSB first) or word[i]
//   (LSB first). Strobe gaps, spurious strobes, busy-time in_valid pulses,
//   aborts and a mid-transfer reset are mixed in.
//   unit 0: WIDTH=8,  MSB_FIRST=1, ACK_SLOT=0
//   unit 1: WIDTH=8,  MSB_FIRST=0, ACK_SLOT=1
//   unit 2: WIDTH=16, MSB_FIRST=1, ACK_SLOT=1
// ---------------------------------------------------------------------------
module tb_shift_serializer;

  localparam int NU = 3;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic [31:0] in_data   [NU];
  logic        in_valid  [NU];
  logic        shift_en  [NU];
  logic        sample_en [NU];
  logic        ack_in    [NU];
  logic        abort_s   [NU];
  logic        in_ready  [NU];
  logic        out_s     [NU];
  logic        busy      [NU];
  logic        done      [NU];
  logic        nack      [NU];

  int uw   [NU] = '{8, 8, 16};
  bit umsb [NU] = '{1'b1, 1'b0, 1'b1};
  bit uack [NU] = '{1'b0, 1'b1, 1'b1};

  // Reference state carried between transactions
  logic out_model  [NU];
  logic nack_model [NU];

  int n_checks = 0;
  int n_errors = 0;

  shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .ACK_SLOT(1'b0)) u0 (
    .clk(clk), .reset(reset), .in_data(in_data[0][7:0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .shift_en(shift_en[0]), .sample_en(sample_en[0]),
    .ack_in(ack_in[0]), .abort(abort_s[0]), .out(out_s[0]), .busy(busy[0]),
    .done(done[0]), .nack(nack[0]));

  shift_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .ACK_SLOT(1'b1)) u1 (
    .clk(clk), .reset(reset), .in_data(in_data[1][7:0]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .shift_en(shift_en[1]), .sample_en(sample_en[1]),
    .ack_in(ack_in[1]), .abort(abort_s[1]), .out(out_s[1]), .busy(busy[1]),
    .done(done[1]), .nack(nack[1]));

  shift_serializer #(.WIDTH(16), .MSB_FIRST(1'b1), .ACK_SLOT(1'b1)) u2 (
    .clk(clk), .reset(reset), .in_data(in_data[2][15:0]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .shift_en(shift_en[2]), .sample_en(sample_en[2]),
    .ack_in(ack_in[2]), .abort(abort_s[2]), .out(out_s[2]), .busy(busy[2]),
    .done(done[2]), .nack(nack[2]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic stream_bit(input int u, input logic [31:0] word, input int i);
    return umsb[u] ? word[uw[u]-1-i] : word[i];
  endfunction

  task automatic check_idle(input int u, input string tag);
    check({tag, "_ready"}, in_ready[u], 1);
    check({tag, "_busy"},  busy[u],     0);
    check({tag, "_out"},   out_s[u],    out_model[u]);
    check({tag, "_done"},  done[u],     0);
    check({tag, "_nack"},  nack[u],     nack_model[u]);
  endtask

  // One transfer. gap = idle cycles before every strobe. abort_at = step
  // index at which abort is raised instead of the strobe (steps 0..W-1 are
  // data bits, W is the release, W+1 the ACK sample); -1 = no abort.
  task automatic run_xfer(input int u, input logic [31:0] word, input int gap,
                          input bit ack_val, input int abort_at);
    int  w      = uw[u];
    int  steps  = uack[u] ? w + 2 : w;
    int  waitc  = 0;
    bit  last;
    while (!in_ready[u] && waitc < 100) begin
      tick();
      waitc++;
    end
    check("ready_wait", in_ready[u], 1);

    in_data[u]  = word;
    in_valid[u] = 1'b1;
    tick();
    in_valid[u] = 1'b0;
    in_data[u]  = $urandom;
    check("load_busy", busy[u], 1);
    check("load_out_hold", out_s[u], out_model[u]);

    for (int i = 0; i < steps; i++) begin
      for (int g = 0; g < gap; g++) begin
        // Busy-time words and irrelevant strobes must have no effect.
        in_valid[u]  = 1'($urandom_range(0, 1));
        in_data[u]   = $urandom;
        sample_en[u] = (i <= w) ? 1'($urandom_range(0, 1)) : 1'b0;
        shift_en[u]  = (i == w + 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        ack_in[u]    = 1'($urandom_range(0, 1));
        tick();
        check("gap_out_hold", out_s[u], out_model[u]);
        check("gap_no_done", done[u], 0);
        check("gap_busy", busy[u], 1);
      end
      in_valid[u]  = 1'b0;
      sample_en[u] = 1'b0;
      shift_en[u]  = 1'b0;

      if (i == abort_at) begin
        abort_s[u]   = 1'b1;
        shift_en[u]  = 1'($urandom_range(0, 1));
        sample_en[u] = 1'($urandom_range(0, 1));
        tick();
        abort_s[u]   = 1'b0;
        shift_en[u]  = 1'b0;
        sample_en[u] = 1'b0;
        out_model[u] = 1'b1;
        check_idle(u, "abort");
        $display("xfer u%0d word=%0h aborted at step %0d", u, word, i);
        return;
      end

      if (i < w) begin
        last         = (i == w - 1);
        shift_en[u]  = 1'b1;
        sample_en[u] = 1'($urandom_range(0, 1));
        ack_in[u]    = 1'($urandom_range(0, 1));
        tick();
        shift_en[u]  = 1'b0;
        sample_en[u] = 1'b0;
        out_model[u] = stream_bit(u, word, i);
        check("bit_out", out_s[u], out_model[u]);
        check("bit_done", done[u], (last && !uack[u]) ? 1 : 0);
        if (last && !uack[u]) check("bit_ready", in_ready[u], 1);
        else                  check("bit_busy", busy[u], 1);
      end else if (i == w) begin
        shift_en[u]  = 1'b1;
        sample_en[u] = 1'($urandom_range(0, 1));
        tick();
        shift_en[u]  = 1'b0;
        sample_en[u] = 1'b0;
        out_model[u] = 1'b1;
        check("rel_out", out_s[u], 1);
        check("rel_done", done[u], 0);
      end else begin
        sample_en[u] = 1'b1;
        shift_en[u]  = 1'($urandom_range(0, 1));
        ack_in[u]    = ack_val;
        tick();
        sample_en[u]  = 1'b0;
        shift_en[u]   = 1'b0;
        nack_model[u] = ack_val;
        check("ack_done", done[u], 1);
        check("ack_nack", nack[u], nack_model[u]);
        check("ack_out", out_s[u], 1);
      end
    end
    tick();
    check_idle(u, "post");
    $display("xfer u%0d word=%0h gap=%0d ack_in=%0b complete", u, word, gap, ack_val);
  endtask

  initial begin
    for (int u = 0; u < NU; u++) begin
      in_data[u] = '0; in_valid[u] = 0; shift_en[u] = 0; sample_en[u] = 0;
      ack_in[u] = 1; abort_s[u] = 0; out_model[u] = 1; nack_model[u] = 0;
    end
    reset = 1'b1;
    repeat (3) tick();
    reset = 1'b0;
    tick();
    for (int u = 0; u < NU; u++) check_idle(u, "reset");

    // Directed cases
    run_xfer(0, 32'hA5, 0, 1'b0, -1);
    run_xfer(1, 32'h01, 0, 1'b1, -1);
    run_xfer(1, 32'h3C, 0, 1'b1, -1);
    run_xfer(1, 32'h3C, 1, 1'b0, -1);
    run_xfer(2, 32'h3C, 0, 1'b1, -1);
    run_xfer(0, 32'hA5, 0, 1'b0, 3);      // abort after the 3rd bit
    run_xfer(0, 32'hFF, 0, 1'b0, -1);
    run_xfer(2, 32'h8001, 3, 1'b0, -1);   // 1 strobe in every 4 cycles
    run_xfer(2, 32'h1234, 0, 1'b1, 16);   // abort in the release slot
    run_xfer(1, 32'h5A, 2, 1'b0, 9);      // abort while waiting for ACK

    // Reset mid-SHIFT with a busy-time word pending
    in_data[0] = 32'h5A; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      shift_en[0] = 1'b1; tick(); shift_en[0] = 1'b0;
    end
    in_data[0] = 32'h00; in_valid[0] = 1'b1;
    tick();
    in_valid[0] = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int u = 0; u < NU; u++) begin
      out_model[u]  = 1'b1;
      nack_model[u] = 1'b0;
    end
    check_idle(0, "midreset");
    for (int k = 0; k < 4; k++) begin
      shift_en[0] = 1'b1; tick(); shift_en[0] = 1'b0;
      check("midreset_no_send", out_s[0], 1);
      check("midreset_idle", busy[0], 0);
    end
    $display("xfer u0 reset mid-transfer, busy-time word dropped");

    // Randomized traffic on every unit
    for (int n = 0; n < 30; n++) begin
      int u  = n % NU;
      int ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, uw[u] + 1)) : -1;
      run_xfer(u, $urandom, $urandom_range(0, 3), 1'($urandom_range(0, 1)), ab);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
